// File: rtl/agc_io_pkg.sv
// agc_io_pkg: shared word type and select-width helper for the AGC I/O hub.
//   WORD_WIDTH : default AGC word width (15)
//   word_t     : one AGC word
//   sel_w(n)   : channel select width for n channels (at least 1)
package agc_io_pkg;
   localparam int WORD_WIDTH = 15;
   typedef logic [WORD_WIDTH-1:0] word_t;
   function automatic int sel_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/agc_io_hub_if.sv
// agc_io_hub_if: Core-side and peripheral-side signals of the AGC I/O hub.
//   master : Core and peripherals (drive requests, input words, output ready, err_clear)
//   slave  : the hub (drives read data, stall, ready/valid, output words, sticky flags)
interface agc_io_hub_if import agc_io_pkg::*; #(
   parameter int WIDTH  = WORD_WIDTH,
   parameter int NUM_CH = 8,
   parameter int SEL_W  = sel_w(NUM_CH)
);
   logic [SEL_W-1:0]              IO_read_sel;
   logic                          IO_read_en;
   logic [WIDTH-1:0]              IO_read_data;
   logic [SEL_W-1:0]              IO_write_sel;
   logic                          IO_write_en;
   logic [WIDTH-1:0]              IO_write_data;
   logic                          stall;
   logic [NUM_CH-1:0][WIDTH-1:0]  ext_in_data;
   logic [NUM_CH-1:0]             ext_in_valid;
   logic [NUM_CH-1:0]             ext_in_ready;
   logic [NUM_CH-1:0][WIDTH-1:0]  ext_out_data;
   logic [NUM_CH-1:0]             ext_out_valid;
   logic [NUM_CH-1:0]             ext_out_ready;
   logic [NUM_CH-1:0]             rd_underflow;
   logic [NUM_CH-1:0]             wr_overflow;
   logic                          err_clear;
   modport master (
      output IO_read_sel, IO_read_en, IO_write_sel, IO_write_en, IO_write_data,
             ext_in_data, ext_in_valid, ext_out_ready, err_clear,
      input  IO_read_data, stall, ext_in_ready, ext_out_data, ext_out_valid,
             rd_underflow, wr_overflow
   );
   modport slave (
      input  IO_read_sel, IO_read_en, IO_write_sel, IO_write_en, IO_write_data,
             ext_in_data, ext_in_valid, ext_out_ready, err_clear,
      output IO_read_data, stall, ext_in_ready, ext_out_data, ext_out_valid,
             rd_underflow, wr_overflow
   );
endinterface

// File: rtl/agc_io_fifo.sv
// agc_io_fifo: per-channel synchronous input FIFO.
//   clock, reset_n : clock, async active-low reset (empties the FIFO)
//   push, din      : write din when not full
//   pop            : drop head when not empty
//   head           : oldest word; full, empty : occupancy status
module agc_io_fifo #(
   parameter int WIDTH = 15,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rp, wp;
   logic [AW:0]      cnt;
   logic             do_push, do_pop;
   assign full    = cnt == (AW+1)'(DEPTH);
   assign empty   = cnt == '0;
   assign head    = mem[rp];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   // storage needs no reset: an empty FIFO never exposes its head
   always_ff @(posedge clock)
      if (do_push) mem[wp] <= din;
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         rp  <= '0;
         wp  <= '0;
         cnt <= '0;
      end else begin
         if (do_push) wp <= wp + AW'(1);
         if (do_pop) rp <= rp + AW'(1);
         cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
endmodule

// File: rtl/agc_io_hub.sv
// agc_io_hub: NUM_CH-channel I/O hub between the AGC Core IO ports and peripherals.
//   clock, reset_n : clock, async active-low reset
//   io (slave)     : Core read/write ports and stall, per-channel input FIFO
//                    valid/ready, one-deep output buffer valid/ready, sticky flags
module agc_io_hub import agc_io_pkg::*; #(
   parameter int                WIDTH      = WORD_WIDTH,
   parameter int                NUM_CH     = 8,
   parameter int                SEL_W      = sel_w(NUM_CH),
   parameter int                FIFO_DEPTH = 4,
   parameter logic [NUM_CH-1:0] BLOCK_MASK = {NUM_CH{1'b1}}
) (
   input logic        clock,
   input logic        reset_n,
   agc_io_hub_if.slave io
);
   logic [NUM_CH-1:0]             empty, full, pop, load, rd_hit;
   logic [WIDTH-1:0]              head [NUM_CH];
   logic [WIDTH-1:0]              last_read [NUM_CH];
   logic [NUM_CH-1:0][WIDTH-1:0]  out_data;
   logic [NUM_CH-1:0]             out_valid, udf, ovf;
   logic [SEL_W-1:0]              rsel, wsel;
   logic rd_in, wr_in, rd_req, wr_req, rd_stall, wr_stall, stall;
   assign rsel   = io.IO_read_sel;
   assign wsel   = io.IO_write_sel;
   // selects beyond NUM_CH are inert: read 0, write ignored, no stall or flags
   assign rd_in  = {1'b0, rsel} < (SEL_W+1)'(NUM_CH);
   assign wr_in  = {1'b0, wsel} < (SEL_W+1)'(NUM_CH);
   assign rd_req = io.IO_read_en && rd_in;
   assign wr_req = io.IO_write_en && wr_in;
   assign rd_stall = rd_req && empty[rsel] && BLOCK_MASK[rsel];
   assign wr_stall = wr_req && out_valid[wsel] && !io.ext_out_ready[wsel] && BLOCK_MASK[wsel];
   // a stall from either side freezes both sides so the Core cycle is atomic
   assign stall    = rd_stall || wr_stall;
   assign io.stall = stall;
   assign io.IO_read_data = !rd_in ? '0 : (rd_req && !empty[rsel]) ? head[rsel] : last_read[rsel];
   assign io.ext_in_ready  = ~full;
   assign io.ext_out_data  = out_data;
   assign io.ext_out_valid = out_valid;
   assign io.rd_underflow  = udf;
   assign io.wr_overflow   = ovf;
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign rd_hit[i] = rd_req && !stall && rsel == SEL_W'(i);
      assign pop[i]    = rd_hit[i] && !empty[i];
      // non-blocking channels reach here even when full: that is the overwrite
      assign load[i]   = wr_req && !stall && wsel == SEL_W'(i);
      agc_io_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
         .clock(clock), .reset_n(reset_n),
         .push(io.ext_in_valid[i]), .pop(pop[i]), .din(io.ext_in_data[i]),
         .head(head[i]), .full(full[i]), .empty(empty[i])
      );
   end
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         for (int i = 0; i < NUM_CH; i++) last_read[i] <= '0;
         out_data  <= '0;
         out_valid <= '0;
         udf       <= '0;
         ovf       <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (pop[i]) last_read[i] <= head[i];
            if (load[i]) out_data[i] <= io.IO_write_data;
         end
         out_valid <= load | (out_valid & ~io.ext_out_ready);
         // clear wins over a same-cycle set
         udf <= io.err_clear ? '0 : udf | (rd_hit & empty);
         ovf <= io.err_clear ? '0 : ovf | (load & out_valid & ~io.ext_out_ready);
      end
endmodule
